// File: rtl/series_ctrl_param.sv
// Control FSM for the iterative series evaluator: load x, MULT_STEPS multiplies and one accumulate per term.
// Strobes are Moore-decoded from state except abort, which kills strobes in the same cycle; no backpressure.
module series_ctrl_param #(
   parameter int                    MULT_STEPS  = 4,
   parameter int                    CNT_W       = 4,
   parameter logic [MULT_STEPS-1:0] SEL_PATTERN = 4'b1100,
   parameter int                    STEP_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  n_terms,
   input  logic              alt_sign,
   input  logic              abort,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic              ldx,
   output logic              initt,
   output logic              ldt,
   output logic              initr,
   output logic              ldr,
   output logic              sel,
   output logic              addci,
   output logic [CNT_W-1:0]  term_idx,
   output logic [STEP_W-1:0] step_idx
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_LOAD  = 3'd2,
      S_MULT  = 3'd3,
      S_ACCUM = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MULT_STEPS - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic                alt_q, alt_d;
   logic                sign_q, sign_d;
   logic [CNT_W-1:0]    term_q, term_d;
   logic [STEP_W-1:0]   step_q, step_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         alt_q   <= 1'b0;
         sign_q  <= 1'b1;
         term_q  <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         alt_q   <= alt_d;
         sign_q  <= sign_d;
         term_q  <= term_d;
         step_q  <= step_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      alt_d   = alt_q;
      sign_d  = sign_q;
      term_d  = term_q;
      step_d  = step_q;
      ready   = 1'b0;
      done    = 1'b0;
      ldx     = 1'b0;
      initt   = 1'b0;
      ldt     = 1'b0;
      initr   = 1'b0;
      ldr     = 1'b0;
      sel     = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (start && !abort) begin
               n_d     = n_terms;
               alt_d   = alt_sign;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            initt  = 1'b1;
            initr  = 1'b1;
            term_d = '0;
            step_d = '0;
            sign_d = 1'b1;
            if (!start) begin
               state_d = (n_q == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            ldx     = 1'b1;
            state_d = S_MULT;
         end
         S_MULT: begin
            ldt = 1'b1;
            sel = SEL_PATTERN[step_q];
            if (step_q == LAST_STEP) begin
               step_d  = '0;
               state_d = S_ACCUM;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         S_ACCUM: begin
            ldr = 1'b1;
            if (alt_q) begin
               sign_d = ~sign_q;
            end
            // n_q is non-zero here: empty runs bypass LOAD/MULT/ACCUM from INIT
            if (term_q == n_q - CNT_W'(1)) begin
               state_d = S_DONE;
            end else begin
               term_d  = term_q + CNT_W'(1);
               state_d = S_MULT;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         ldx     = 1'b0;
         initt   = 1'b0;
         ldt     = 1'b0;
         initr   = 1'b0;
         ldr     = 1'b0;
         done    = 1'b0;
         state_d = S_IDLE;
         term_d  = '0;
         step_d  = '0;
         sign_d  = 1'b1;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign addci    = sign_q;
   assign term_idx = term_q;
   assign step_idx = step_q;

endmodule
